// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings, control states and datapath sizing.
package mdu_pkg;

    localparam int DATA_W = 32;
    localparam int ITERS  = 32;
    localparam int CNT_W  = 6;

    typedef enum logic [1:0] {
        MDU_MULTU = 2'b00,
        MDU_MULT  = 2'b01,
        MDU_DIVU  = 2'b10,
        MDU_DIV   = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIN  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_cond_neg.sv
// Conditional two's-complement negate, used both for operand magnitudes and
// for sign correction of results.
module mdu_cond_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? -a : a;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit: one bit per cycle (shift-add or
// restoring shift-subtract) on operand magnitudes, sign-corrected at the end.
module mul_div_unit
    import mdu_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        MDUCtrl,
    input  logic [DATA_W-1:0] SrcA,
    input  logic [DATA_W-1:0] SrcB,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              div_by_zero
);

    mdu_state_e        state, state_nxt;
    mdu_op_e           op_r;
    logic              sign_a, sign_b;
    logic [DATA_W-1:0] opnd;
    logic [DATA_W-1:0] acc_hi, acc_lo;
    logic [CNT_W-1:0]  cnt;
    logic              accept, step, finish;

    // Operand magnitudes are taken from the live inputs on the accepting edge.
    logic              in_neg_a, in_neg_b;
    logic [DATA_W-1:0] abs_a, abs_b;

    assign in_neg_a = MDUCtrl[0] & SrcA[DATA_W-1];
    assign in_neg_b = MDUCtrl[0] & SrcB[DATA_W-1];

    mdu_cond_neg #(.W(DATA_W)) u_abs_a (.a(SrcA), .neg(in_neg_a), .y(abs_a));
    mdu_cond_neg #(.W(DATA_W)) u_abs_b (.a(SrcB), .neg(in_neg_b), .y(abs_b));

    // One iteration of each algorithm; acc_lo holds multiplier or dividend/quotient.
    logic [DATA_W:0] mul_sum, div_shift, div_diff;
    logic            div_ge;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    assign div_shift = {acc_hi, acc_lo[DATA_W-1]};
    assign div_ge    = div_shift >= {1'b0, opnd};
    assign div_diff  = div_shift - {1'b0, opnd};

    // Result correction: remainder takes the dividend's sign.
    logic                neg_prod, neg_quo, neg_rem, is_div, dbz;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quo_fix, rem_fix;

    assign is_div   = op_r[1];
    assign dbz      = is_div && (opnd == '0);
    assign neg_prod = (op_r == MDU_MULT) && (sign_a ^ sign_b);
    assign neg_quo  = (op_r == MDU_DIV) && (sign_a ^ sign_b);
    assign neg_rem  = (op_r == MDU_DIV) && sign_a;

    mdu_cond_neg #(.W(2*DATA_W)) u_fix_prod (.a({acc_hi, acc_lo}), .neg(neg_prod), .y(prod_fix));
    mdu_cond_neg #(.W(DATA_W))   u_fix_quo  (.a(acc_lo), .neg(neg_quo), .y(quo_fix));
    mdu_cond_neg #(.W(DATA_W))   u_fix_rem  (.a(acc_hi), .neg(neg_rem), .y(rem_fix));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        finish    = 1'b0;
        unique case (state)
            S_IDLE: if (start) begin
                accept    = 1'b1;
                state_nxt = S_CALC;
            end
            S_CALC: begin
                step = 1'b1;
                if (cnt == CNT_W'(ITERS - 1)) state_nxt = S_FIN;
            end
            S_FIN: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r        <= MDU_MULTU;
            sign_a      <= 1'b0;
            sign_b      <= 1'b0;
            opnd        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            if (accept) begin
                op_r   <= mdu_op_e'(MDUCtrl);
                sign_a <= in_neg_a;
                sign_b <= in_neg_b;
                opnd   <= MDUCtrl[1] ? abs_b : abs_a;
                acc_lo <= MDUCtrl[1] ? abs_a : abs_b;
                acc_hi <= '0;
                cnt    <= '0;
            end
            if (step) begin
                cnt <= cnt + 1'b1;
                if (is_div) begin
                    acc_hi <= div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
                    acc_lo <= {acc_lo[DATA_W-2:0], div_ge};
                end else begin
                    acc_hi <= mul_sum[DATA_W:1];
                    acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
                end
            end
            if (finish) begin
                done <= 1'b1;
                if (is_div) begin
                    hi          <= rem_fix;
                    lo          <= dbz ? '1 : quo_fix;
                    div_by_zero <= dbz;
                end else begin
                    {hi, lo} <= prod_fix;
                end
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes hand-computed results,
// a negedge monitor pops and compares whenever done is presented.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  MDUCtrl = 2'b00;
    logic [31:0] SrcA = '0, SrcB = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    mul_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .MDUCtrl(MDUCtrl),
        .SrcA(SrcA), .SrcB(SrcB), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare on every completion, and keep div_by_zero low otherwise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check({e.name, ".hi"}, 64'(hi), 64'(e.hi));
                    check({e.name, ".lo"}, 64'(lo), 64'(e.lo));
                    check({e.name, ".dbz"}, 64'(div_by_zero), 64'(e.dbz));
                    check({e.name, ".latency"}, 64'(cyc), 64'(e.cyc));
                    check({e.name, ".busy_at_done"}, 64'(busy), 64'(0));
                end
            end else begin
                check("dbz_without_done", 64'(div_by_zero), 64'(0));
            end
        end
    end

    // Called at a negedge with the unit idle (or in its done cycle).
    task automatic run_op(input string name, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el,
                          input logic ed, input int pulse_at);
        exp_t e;
        bit   seen;
        start = 1'b1; MDUCtrl = op; SrcA = a; SrcB = b;
        @(posedge clk);
        #1;
        e.hi = eh; e.lo = el; e.dbz = ed; e.cyc = cyc + 33; e.name = name;
        sb.push_back(e);
        start = 1'b0; MDUCtrl = ~op; SrcA = $urandom; SrcB = $urandom;
        check({name, ".busy_after_accept"}, 64'(busy), 64'(1));
        if (pulse_at > 0) begin
            repeat (pulse_at) @(negedge clk);
            start = 1'b1; MDUCtrl = 2'b10; SrcA = 32'd100; SrcB = 32'd0;
            @(negedge clk);
            start = 1'b0;
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) check({name, ".timeout"}, 64'(seen), 64'(1));
    endtask

    initial begin
        #12;
        check("reset.busy", 64'(busy), 64'(0));
        check("reset.done", 64'(done), 64'(0));
        check("reset.hilo", {hi, lo}, 64'(0));
        check("reset.dbz", 64'(div_by_zero), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0);
        run_op("mult_neg5x2", 2'b01, 32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFF6, 1'b0, 0);
        run_op("mult_maxpos", 2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op("div_neg7by2", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("divu_7by2", 2'b10, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0, 0);
        run_op("div_min_by_m1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0, 0);
        run_op("divu_5by0", 2'b10, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("div_neg7by0", 2'b11, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, 0);
        run_op("div_7by_neg2", 2'b11, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 0);
        run_op("multu_ignore_start", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 5);

        // Abort a signed multiply with an asynchronous reset mid-flight.
        start = 1'b1; MDUCtrl = 2'b01; SrcA = 32'h1234_5678; SrcB = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'(0));
        check("abort.done", 64'(done), 64'(0));
        check("abort.hilo", {hi, lo}, 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        run_op("multu_after_reset", 2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 0);

        repeat (40) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
